// File: rtl/neosd_pkg.sv
// Shared types and constants for the neosd CMD-line blocks.
// Also holds the one-bit CRC7 update used by the serial CRC unit.
package neosd_pkg;

    typedef enum logic [1:0] {
        RSP_NONE     = 2'd0,
        RSP_48       = 2'd1,
        RSP_48_NOCRC = 2'd2,
        RSP_136      = 2'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StCheck,
        StDeliver,
        StWaitRsp,
        StNcr,
        StTx
    } cmd_state_e;

    localparam int unsigned CMD_FRAME_BITS = 48;
    localparam int unsigned RSP_LONG_BITS  = 136;
    localparam logic [6:0]  CRC7_POLY      = 7'h09;

    // One shift of the x^7 + x^3 + 1 generator, message bit entering at the top.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one message bit per enabled clock.
// clr_i together with en_i restarts the CRC with bit_i as the first message bit.
module neosd_crc7
    import neosd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_base;

    assign crc_base = clr_i ? 7'h00 : crc_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crc_q <= 7'h00;
        end else if (en_i) begin
            crc_q <= crc7_step(crc_base, bit_i);
        end else if (clr_i) begin
            crc_q <= 7'h00;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD line: receives 48-bit host commands, hands them to card logic
// and serialises the R1/R2/R3/R6/R7 (or no) response back onto the line.
module neosd_card_cmd
    import neosd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NCR         = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         sd_clk_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    output logic         cmd_valid_o,
    input  logic         cmd_ready_i,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    output logic         crc_err_o,
    input  logic         rsp_valid_i,
    output logic         rsp_ready_o,
    input  logic [1:0]   rsp_type_i,
    input  logic [5:0]   rsp_idx_i,
    input  logic [119:0] rsp_data_i,
    output logic         busy_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cmd_sync_q;
    logic                   clk_prev_q;
    logic                   sd_clk_s;
    logic                   sd_cmd_s;
    logic                   rise;
    logic                   fall;

    cmd_state_e state_q, state_d;
    logic [47:0]  rx_q, rx_d;
    logic [135:0] tx_q, tx_d;
    logic [7:0]   cnt_q, cnt_d;
    rsp_type_e    type_q, type_d;
    logic [5:0]   idx_q, idx_d;
    logic [31:0]  arg_q, arg_d;
    logic         crc_err_q, crc_err_d;
    logic         out_q, out_d;
    logic         oe_q, oe_d;

    logic       crc_clr;
    logic       crc_en;
    logic       crc_bit;
    logic [6:0] crc;

    logic [7:0] frame_len;
    logic [7:0] crc_pos;
    logic [2:0] crc_sel;
    logic       tx_feed;

    // The CMD line idles high, so its synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            clk_sync_q <= '0;
            cmd_sync_q <= '1;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sd_clk_i};
            cmd_sync_q <= {cmd_sync_q[SYNC_STAGES-2:0], sd_cmd_i};
            clk_prev_q <= sd_clk_s;
        end
    end

    assign sd_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign sd_cmd_s = cmd_sync_q[SYNC_STAGES-1];
    assign rise     = sd_clk_s & ~clk_prev_q;
    assign fall     = ~sd_clk_s & clk_prev_q;

    neosd_crc7 u_crc7 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .bit_i  (crc_bit),
        .crc_o  (crc)
    );

    assign frame_len = (type_q == RSP_136) ? 8'(RSP_LONG_BITS) : 8'(CMD_FRAME_BITS);
    assign crc_pos   = cnt_q - (frame_len - 8'd8);
    assign crc_sel   = 3'(8'd6 - crc_pos);
    // R2 CRC covers only the 120 payload bits, not the 8-bit header.
    assign tx_feed   = (type_q == RSP_48) || ((type_q == RSP_136) && (cnt_q >= 8'd8));

    always_comb begin
        state_d   = state_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        crc_err_d = 1'b0;
        out_d     = out_q;
        oe_d      = oe_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        crc_bit   = 1'b0;

        case (state_q)
            StIdle: begin
                if (rise && !sd_cmd_s) begin
                    crc_clr = 1'b1;
                    crc_en  = 1'b1;
                    crc_bit = sd_cmd_s;
                    rx_d    = {47'b0, sd_cmd_s};
                    cnt_d   = 8'd1;
                    state_d = StRx;
                end
            end
            StRx: begin
                if (rise) begin
                    rx_d  = {rx_q[46:0], sd_cmd_s};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q < 8'd40) begin
                        crc_en  = 1'b1;
                        crc_bit = sd_cmd_s;
                    end
                    if (cnt_q == 8'd47) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (rx_q[47] || !rx_q[46] || !rx_q[0]) begin
                    state_d = StIdle;
                end else if (rx_q[7:1] != crc) begin
                    crc_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    idx_d   = rx_q[45:40];
                    arg_d   = rx_q[39:8];
                    state_d = StDeliver;
                end
            end
            StDeliver: begin
                if (cmd_ready_i) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (rsp_valid_i) begin
                    if (rsp_type_e'(rsp_type_i) == RSP_NONE) begin
                        state_d = StIdle;
                    end else begin
                        type_d  = rsp_type_e'(rsp_type_i);
                        cnt_d   = 8'd0;
                        crc_clr = 1'b1;
                        state_d = StNcr;
                        if (rsp_type_e'(rsp_type_i) == RSP_136) begin
                            tx_d = {2'b00, 6'h3F, rsp_data_i, 8'h00};
                        end else begin
                            tx_d = {2'b00, rsp_idx_i, rsp_data_i[31:0], 96'b0};
                        end
                    end
                end
            end
            StNcr: begin
                if (fall) begin
                    if (cnt_q == 8'(NCR - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = StTx;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StTx: begin
                if (fall) begin
                    if (cnt_q == frame_len) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        oe_d  = 1'b1;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q < frame_len - 8'd8) begin
                            out_d   = tx_q[135];
                            tx_d    = {tx_q[134:0], 1'b0};
                            crc_en  = tx_feed;
                            crc_bit = tx_q[135];
                        end else if (cnt_q < frame_len - 8'd1) begin
                            out_d = (type_q == RSP_48_NOCRC) ? 1'b1 : crc[crc_sel];
                        end else begin
                            out_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            rx_q      <= '0;
            tx_q      <= '0;
            cnt_q     <= '0;
            type_q    <= RSP_NONE;
            idx_q     <= '0;
            arg_q     <= '0;
            crc_err_q <= 1'b0;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            crc_err_q <= crc_err_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
        end
    end

    assign sd_cmd_o    = out_q;
    assign sd_cmd_oe   = oe_q;
    assign cmd_valid_o = (state_q == StDeliver);
    assign rsp_ready_o = (state_q == StWaitRsp);
    assign cmd_idx_o   = idx_q;
    assign cmd_arg_o   = arg_q;
    assign crc_err_o   = crc_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Directed bench for neosd_card_cmd: host command frames in, card responses
// captured on the sd_clk rising edge and compared with a long-division CRC7 model.
module tb_neosd_card_cmd;
    import neosd_pkg::*;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         sd_clk_i = 1'b0;
    logic         sd_cmd_i = 1'b1;
    logic         sd_cmd_o;
    logic         sd_cmd_oe;
    logic         cmd_valid_o;
    logic         cmd_ready_i = 1'b0;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         crc_err_o;
    logic         rsp_valid_i = 1'b0;
    logic         rsp_ready_o;
    logic [1:0]   rsp_type_i = 2'd0;
    logic [5:0]   rsp_idx_i = 6'd0;
    logic [119:0] rsp_data_i = '0;
    logic         busy_o;

    int vectors = 0;
    int miscompares = 0;
    int crc_pulses = 0;
    int valid_cycles = 0;
    int oe_cycles = 0;

    neosd_card_cmd #(
        .SYNC_STAGES (2),
        .NCR         (2)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .sd_clk_i    (sd_clk_i),
        .sd_cmd_i    (sd_cmd_i),
        .sd_cmd_o    (sd_cmd_o),
        .sd_cmd_oe   (sd_cmd_oe),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_idx_o   (cmd_idx_o),
        .cmd_arg_o   (cmd_arg_o),
        .crc_err_o   (crc_err_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_type_i  (rsp_type_i),
        .rsp_idx_i   (rsp_idx_i),
        .rsp_data_i  (rsp_data_i),
        .busy_o      (busy_o)
    );

    // clk_i = 100 MHz, sd_clk = 6.25 MHz (16x), edges offset from clk_i edges.
    always #5 clk_i = ~clk_i;
    initial begin
        #3;
        forever #80 sd_clk_i = ~sd_clk_i;
    end

    always @(negedge clk_i) begin
        if (crc_err_o) crc_pulses++;
        if (cmd_valid_o) valid_cycles++;
        if (sd_cmd_oe) oe_cycles++;
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference CRC7 by polynomial long division over the n low bits of msg.
    function automatic logic [6:0] crc7_model(input logic [127:0] msg, input int n);
        logic [134:0] r;
        r = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--) begin
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic send_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk_i);
            sd_cmd_i = f[i];
        end
        @(negedge sd_clk_i);
        sd_cmd_i = 1'b1;
    endtask

    task automatic accept_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (cmd_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, 136'(ok), 136'd1);
        check({tag, "_idx"}, 136'(cmd_idx_o), 136'(idx));
        check({tag, "_arg"}, 136'(cmd_arg_o), 136'(arg));
        cmd_ready_i = 1'b1;
        @(negedge clk_i);
        cmd_ready_i = 1'b0;
        check({tag, "_rsp_ready"}, 136'(rsp_ready_o), 136'd1);
    endtask

    // Handshake aligned just after an sd_clk rise; with NCR=2 the line stays released
    // for two rises and the start bit is seen on the third.
    task automatic do_rsp(input string tag, input logic [1:0] t, input logic [5:0] idx,
                          input logic [119:0] data, input int n, input int abort_at,
                          output logic [135:0] bits);
        logic oe_all;
        bits   = '0;
        oe_all = 1'b1;
        @(posedge sd_clk_i);
        @(negedge clk_i);
        rsp_type_i  = t;
        rsp_idx_i   = idx;
        rsp_data_i  = data;
        rsp_valid_i = 1'b1;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        @(posedge sd_clk_i);
        check({tag, "_ncr1_oe"}, 136'(sd_cmd_oe), 136'd0);
        @(posedge sd_clk_i);
        check({tag, "_ncr2_oe"}, 136'(sd_cmd_oe), 136'd0);
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge sd_clk_i);
            bits[i] = sd_cmd_o;
            oe_all  = oe_all & sd_cmd_oe;
            if (n - i == abort_at) begin
                #20 rstn_i = 1'b0;
                #1;
                check({tag, "_rst_oe"}, 136'(sd_cmd_oe), 136'd0);
                check({tag, "_rst_out"}, 136'(sd_cmd_o), 136'd1);
                return;
            end
        end
        check({tag, "_oe_during"}, 136'(oe_all), 136'd1);
        @(posedge sd_clk_i);
        check({tag, "_oe_after"}, 136'(sd_cmd_oe), 136'd0);
        check({tag, "_out_after"}, 136'(sd_cmd_o), 136'd1);
    endtask

    localparam logic [47:0] CMD0     = 48'h40_00000000_95;
    localparam logic [47:0] CMD8     = 48'h48_000001AA_87;
    localparam logic [47:0] CMD8_END = 48'h48_000001AA_86;
    localparam logic [47:0] CMD8_CRC = 48'h48_000001AA_89;

    initial begin
        logic [135:0] bits;
        logic [47:0]  e48;
        logic [135:0] e136;
        logic [119:0] d136;
        int           snap_a;
        int           snap_b;

        // Reset state
        repeat (4) @(negedge clk_i);
        check("rst_out", 136'(sd_cmd_o), 136'd1);
        check("rst_oe", 136'(sd_cmd_oe), 136'd0);
        check("rst_valid", 136'(cmd_valid_o), 136'd0);
        check("rst_rsp_ready", 136'(rsp_ready_o), 136'd0);
        check("rst_crc_err", 136'(crc_err_o), 136'd0);
        check("rst_idx", 136'(cmd_idx_o), 136'd0);
        check("rst_arg", 136'(cmd_arg_o), 136'd0);
        check("rst_busy", 136'(busy_o), 136'd0);
        rstn_i = 1'b1;
        repeat (20) @(negedge clk_i);

        // CMD0, then no response
        snap_a = crc_pulses;
        send_cmd(CMD0);
        accept_cmd("cmd0", 6'd0, 32'h0000_0000);
        check("cmd0_no_crc_err", 136'(crc_pulses - snap_a), 136'd0);
        snap_b = oe_cycles;
        rsp_type_i  = RSP_NONE;
        rsp_valid_i = 1'b1;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        check("none_busy", 136'(busy_o), 136'd0);
        repeat (200) @(negedge clk_i);
        check("none_line_idle", 136'(oe_cycles - snap_b), 136'd0);

        // CMD8 with R7 echo
        send_cmd(CMD8);
        accept_cmd("cmd8", 6'd8, 32'h0000_01AA);
        e48 = {2'b00, 6'd8, 32'h0000_01AA,
               crc7_model(128'({2'b00, 6'd8, 32'h0000_01AA}), 40), 1'b1};
        do_rsp("r7", RSP_48, 6'd8, 120'h1AA, 48, -1, bits);
        check("r7_frame", bits, 136'(e48));

        // Bad end bit: silently dropped
        snap_a = crc_pulses;
        snap_b = valid_cycles;
        send_cmd(CMD8_END);
        repeat (20) @(negedge clk_i);
        check("end_no_valid", 136'(valid_cycles - snap_b), 136'd0);
        check("end_no_crc_err", 136'(crc_pulses - snap_a), 136'd0);
        check("end_busy", 136'(busy_o), 136'd0);

        // Bad CRC: one-clock crc_err_o
        snap_a = crc_pulses;
        snap_b = valid_cycles;
        send_cmd(CMD8_CRC);
        repeat (20) @(negedge clk_i);
        check("crc_pulse_cycles", 136'(crc_pulses - snap_a), 136'd1);
        check("crc_no_valid", 136'(valid_cycles - snap_b), 136'd0);

        // R2 136-bit response
        send_cmd(CMD0);
        accept_cmd("cmd0_r2", 6'd0, 32'h0);
        d136 = 120'h0123_4567_89AB_CDEF_0123_4567_89AB_CD;
        e136 = {2'b00, 6'h3F, d136, crc7_model(128'(d136), 120), 1'b1};
        do_rsp("r2", RSP_136, 6'd0, d136, 136, -1, bits);
        check("r2_frame", bits, e136);

        // R3 without CRC
        send_cmd(CMD0);
        accept_cmd("cmd0_r3", 6'd0, 32'h0);
        e48 = {2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
        do_rsp("r3", RSP_48_NOCRC, 6'h3F, 120'h80FF_8000, 48, -1, bits);
        check("r3_frame", bits, 136'(e48));
        check("r3_crc_ones", 136'(bits[7:1]), 136'h7F);

        // Reset in the middle of a response
        send_cmd(CMD0);
        accept_cmd("cmd0_abort", 6'd0, 32'h0);
        do_rsp("abort", RSP_48, 6'd1, 120'h1234_5678, 48, 20, bits);
        repeat (5) @(negedge clk_i);
        check("abort_busy", 136'(busy_o), 136'd0);
        rstn_i = 1'b1;
        repeat (20) @(negedge clk_i);
        send_cmd(CMD0);
        accept_cmd("cmd0_after_rst", 6'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neosd_card_cmd.md
Name: neosd_card_cmd

Overview:
Card-side (device) end of the SD CMD line. It receives 48-bit command tokens sent by the host on sd_cmd_i, validates framing and CRC7, and hands the index and argument to card logic through a valid/ready handshake. It then serialises the card logic's response (R1/R3/R6/R7 48-bit, R2 136-bit, or none) back onto the CMD line. It is used as the card model in system benches and as the front end of an FPGA SD-card emulator. Everything runs in the clk_i domain; sd_clk_i is oversampled.

Parameters:
SYNC_STAGES, 2, synchroniser depth for sd_clk_i and sd_cmd_i.
NCR, 2, number of sd_clk falling edges with the line released between response handshake and start bit (legal 2..64).

Ports:
clk_i  in  1  system clock; must be at least 8x the sd_clk frequency
rstn_i  in  1  reset
sd_clk_i  in  1  SD clock from host, asynchronous
sd_cmd_i  in  1  CMD line input, asynchronous
sd_cmd_o  out  1  CMD line drive value
sd_cmd_oe  out  1  CMD line output enable
cmd_valid_o  out  1  received command available
cmd_ready_i  in  1  card logic accepts command
cmd_idx_o  out  6  command index
cmd_arg_o  out  32  command argument
crc_err_o  out  1  one-cycle pulse: command dropped due to CRC7 mismatch
rsp_valid_i  in  1  response available from card logic
rsp_ready_o  out  1  block accepts response
rsp_type_i  in  2  RSP_NONE / RSP_48 / RSP_48_NOCRC / RSP_136
rsp_idx_i  in  6  index field (48-bit types only)
rsp_data_i  in  120  payload; [31:0] for 48-bit types, [119:0] = CID/CSD[127:8] for RSP_136
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous, active-low on rstn_i; clock clk_i. Reset values: sd_cmd_o=1, sd_cmd_oe=0, cmd_valid_o=0, rsp_ready_o=0, crc_err_o=0, cmd_idx_o=0, cmd_arg_o=0, busy_o=0, FSM=IDLE. A reset during TX releases the line immediately.
- Edge detection: sd_clk_i and sd_cmd_i each pass through SYNC_STAGES flops. rise = sync_clk & ~prev; fall = ~sync_clk & prev. The CMD line is sampled on rise and driven only on fall.
- IDLE: on a rise with sampled cmd=0 (start bit), clear CRC, feed the bit, go to RX with bit count 1.
- RX: shift one bit per rise until 48 bits are held. Bits 47..8 feed CRC7 (x^7+x^3+1, init 0). Then go to CHECK.
- CHECK (1 clk):
  - Transmission bit (bit 46) = 0 or end bit (bit 0) = 0: framing error; drop silently, go to IDLE.
  - Bits 7:1 != CRC7: pulse crc_err_o for one clk, go to IDLE.
  - Otherwise load cmd_idx_o and cmd_arg_o, go to DELIVER.
- DELIVER: cmd_valid_o=1, with idx/arg held stable. On cmd_valid_o & cmd_ready_i, drop valid next clk and go to WAIT_RSP.
- WAIT_RSP: rsp_ready_o=1. On handshake:
  - RSP_NONE: go to IDLE.
  - Otherwise latch type/idx/data into the shift register, build the frame, clear the counter, go to NCR.
- Frame construction:
  - RSP_48 and RSP_48_NOCRC: 0, 0, idx[5:0], data[31:0], then 7 CRC bits, then 1.
  - RSP_136: 0, 0, 111111, data[119:0], then 7 CRC bits, then 1.
  - CRC bits: computed on the fly for RSP_48 (over bits 47:8) and RSP_136 (over the 120 data bits only). Forced to 1111111 for RSP_48_NOCRC.
- NCR: sd_cmd_oe=0. Count NCR fall events, then go to TX.
- TX: on each fall, drive the next bit with sd_cmd_oe=1, MSB first. The start bit is therefore driven on the (NCR+1)th fall after the handshake. After the end bit has been driven, the next fall sets sd_cmd_oe=0, sd_cmd_o=1, and the FSM returns to IDLE.
- Host traffic on sd_cmd_i during DELIVER, WAIT_RSP, NCR and TX is ignored.
- If sd_clk stops, the FSM holds its state indefinitely; there is no timeout.
- Simultaneous rise and fall cannot occur in the same clk (edge detector on a single synchronised signal).

Decomposition:
- neosd_pkg holds:
  - rsp_type_e enum (RSP_NONE=0, RSP_48=1, RSP_48_NOCRC=2, RSP_136=3)
  - CMD_FRAME_BITS=48, RSP_LONG_BITS=136
  - CRC7_POLY=7'h09
- One sub-module: neosd_crc7, a serial CRC7 with clr_i, en_i, bit_i and crc_o. It is also reused by the host-side FSM.

Test Plan:
- CMD0 frame 0x40_00000000_95 at 400 kHz equivalent, clk_i = 16x -> cmd_valid_o with idx=0, arg=0x00000000; crc_err_o stays 0.
- CMD8 frame 0x48_000001AA_87, then RSP_48 with idx=8, data=0x000001AA -> start bit driven on the 3rd fall (NCR=2) after handshake. The 48 captured bits match the bench model, including CRC7 over bits 47:8 and end bit 1. oe drops one fall after the end bit.
- CMD8 frame with last byte 0x86 (end bit 0) -> no cmd_valid_o, no crc_err_o, FSM back to IDLE. Last byte 0x89 (bad CRC) -> single-clk crc_err_o, no cmd_valid_o.
- RSP_136 with data=0x0123..(120 bits) -> 136 bits observed: header 0b00111111, data MSB first, model CRC7, end bit 1.
- RSP_48_NOCRC with idx=6'h3F, data=0x80FF8000 (R3) -> bits 7:1 = 1111111. Then RSP_NONE -> line never driven, busy_o low on the next clk.
- Assert rstn_i mid-TX (bit 20) -> sd_cmd_oe=0 and sd_cmd_o=1 asynchronously. After release, a new CMD0 is received correctly.
